// File: rtl/coin_acceptor.sv
// Coin-slot sensor conditioner: per-channel sync + debounce FSM, then a
// 1-yuan-priority arbiter steering one event per cycle to coin or reject.

module coin_ch #(
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic s,
  output logic qual
);
  typedef enum logic {IDLE, HELD} st_t;
  localparam int CW = $clog2(DEBOUNCE_CYC);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYC - 1);

  st_t           st;
  logic [CW-1:0] cnt;

  // Combinational so the output register in the top absorbs the qualify cycle.
  assign qual = (st == IDLE) && s && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= HELD;
      cnt <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (!s)               cnt <= '0;
          else if (cnt == LAST) begin
            cnt <= '0;
            st  <= HELD;
          end else              cnt <= cnt + 1'b1;
        end
        HELD: begin
          if (s)                cnt <= '0;
          else if (cnt == LAST) begin
            cnt <= '0;
            st  <= IDLE;
          end else              cnt <= cnt + 1'b1;
        end
        default: begin
          st  <= HELD;
          cnt <= '0;
        end
      endcase
    end
  end
endmodule

module coin_acceptor #(
  parameter int DEBOUNCE_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_half,
  input  logic       sw_one,
  input  logic       accept_en,
  output logic [1:0] coin,
  output logic [1:0] reject
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0] raw, meta, s_lvl, qual;
  logic              half_pend, pend_nxt;
  logic [1:0]        code;

  assign raw = {sw_one, sw_half};

  always_ff @(posedge clk) begin
    if (rst) begin
      meta  <= '0;
      s_lvl <= '0;
    end else begin
      meta  <= raw;
      s_lvl <= meta;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    coin_ch #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_ch (
      .clk  (clk),
      .rst  (rst),
      .s    (s_lvl[g]),
      .qual (qual[g])
    );
  end

  // A half event losing to 1-yuan waits one cycle; channels can't requalify
  // faster than DEBOUNCE_CYC, so a single pending slot never overflows.
  always_comb begin
    code     = 2'b00;
    pend_nxt = half_pend;
    if (qual[1]) begin
      code     = 2'b10;
      pend_nxt = half_pend | qual[0];
    end else if (half_pend || qual[0]) begin
      code     = 2'b01;
      pend_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      half_pend <= 1'b0;
      coin      <= 2'b00;
      reject    <= 2'b00;
    end else begin
      half_pend <= pend_nxt;
      coin      <= accept_en ? code  : 2'b00;
      reject    <= accept_en ? 2'b00 : code;
    end
  end
endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor with DEBOUNCE_CYC=4; events are logged at
// negedge with their cycle number and compared against hand-derived timing.

module tb_coin_acceptor;
  logic       clk = 1'b0;
  logic       rst;
  logic       sw_half, sw_one, accept_en;
  logic [1:0] coin, reject;

  int n_tot = 0;
  int n_bad = 0;
  int cyc   = 0;
  int r;

  int       ev_cyc[$];
  bit [1:0] ev_coin[$];
  bit [1:0] ev_rej[$];

  coin_acceptor #(.DEBOUNCE_CYC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sw_half   (sw_half),
    .sw_one    (sw_one),
    .accept_en (accept_en),
    .coin      (coin),
    .reject    (reject)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    n_tot++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (coin != 2'b00 || reject != 2'b00) begin
      chk("excl", int'(coin != 2'b00 && reject != 2'b00), 0);
      ev_cyc.push_back(cyc);
      ev_coin.push_back(coin);
      ev_rej.push_back(reject);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_ev();
    ev_cyc.delete();
    ev_coin.delete();
    ev_rej.delete();
  endtask

  task automatic chk_ev(input string tag, input int idx, input int ecyc,
                        input int ecoin, input int erej);
    if (idx < ev_cyc.size()) begin
      chk({tag, ".cyc"},  ev_cyc[idx],       ecyc);
      chk({tag, ".coin"}, int'(ev_coin[idx]), ecoin);
      chk({tag, ".rej"},  int'(ev_rej[idx]),  erej);
    end
  endtask

  initial begin
    rst = 1'b1; sw_one = 1'b1; sw_half = 1'b0; accept_en = 1'b1;
    // 1: stuck sensor through reset
    tick(3);
    chk("rst.coin", int'(coin), 0);
    chk("rst.rej",  int'(reject), 0);
    rst = 1'b0;
    tick(20);
    chk("stuck.n", ev_cyc.size(), 0);
    sw_one = 1'b0; tick(8);
    clr_ev();
    sw_one = 1'b1; r = cyc; tick(10);
    sw_one = 1'b0; tick(10);
    chk("t1.n", ev_cyc.size(), 1);
    chk_ev("t1", 0, r + 6, 2, 0);
    clr_ev();

    // 2: clean half press
    sw_half = 1'b1; r = cyc; tick(10);
    sw_half = 1'b0; tick(10);
    chk("t2.n", ev_cyc.size(), 1);
    chk_ev("t2", 0, r + 6, 1, 0);
    clr_ev();

    // boundary: 3-cycle pulse rejected, 4-cycle pulse qualifies
    sw_half = 1'b1; tick(3); sw_half = 1'b0; tick(10);
    chk("short.n", ev_cyc.size(), 0);
    sw_half = 1'b1; r = cyc; tick(4); sw_half = 1'b0; tick(12);
    chk("exact.n", ev_cyc.size(), 1);
    chk_ev("exact", 0, r + 6, 1, 0);
    clr_ev();

    // 3: bouncy press and bouncy release
    for (int i = 0; i < 6; i++) begin
      sw_one = ~i[0]; tick(2);
    end
    sw_one = 1'b1; r = cyc; tick(10);
    for (int i = 0; i < 6; i++) begin
      sw_one = i[0]; tick(2);
    end
    sw_one = 1'b0; tick(10);
    chk("t3.n", ev_cyc.size(), 1);
    chk_ev("t3", 0, r + 6, 2, 0);
    clr_ev();

    // 4: simultaneous
    sw_half = 1'b1; sw_one = 1'b1; r = cyc; tick(10);
    sw_half = 1'b0; sw_one = 1'b0; tick(10);
    chk("t4.n", ev_cyc.size(), 2);
    chk_ev("t4a", 0, r + 6, 2, 0);
    chk_ev("t4b", 1, r + 7, 1, 0);
    clr_ev();

    // 5: reject, then simultaneous with accept_en dropping before deferred half
    accept_en = 1'b0;
    sw_one = 1'b1; r = cyc; tick(10);
    sw_one = 1'b0; tick(10);
    chk("t5a.n", ev_cyc.size(), 1);
    chk_ev("t5a", 0, r + 6, 0, 2);
    clr_ev();
    accept_en = 1'b1;
    sw_half = 1'b1; sw_one = 1'b1; r = cyc; tick(6);
    accept_en = 1'b0; tick(4);
    sw_half = 1'b0; sw_one = 1'b0; tick(10);
    accept_en = 1'b1;
    chk("t5b.n", ev_cyc.size(), 2);
    chk_ev("t5b0", 0, r + 6, 2, 0);
    chk_ev("t5b1", 1, r + 7, 0, 1);
    clr_ev();

    // 6: reset mid-debounce
    sw_half = 1'b1; tick(4);
    rst = 1'b1; tick(2);
    chk("t6.rst.coin", int'(coin), 0);
    rst = 1'b0; tick(15);
    chk("t6.held.n", ev_cyc.size(), 0);
    sw_half = 1'b0; tick(10);
    sw_half = 1'b1; r = cyc; tick(10);
    sw_half = 1'b0; tick(10);
    chk("t6.n", ev_cyc.size(), 1);
    chk_ev("t6", 0, r + 6, 1, 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule

// File: doc/coin_acceptor.md
# coin_acceptor

Front-end coin sensor conditioner for the vending machine. It takes two raw, bouncy, asynchronous coin-slot sensor lines (0.5-yuan and 1-yuan), synchronizes and debounces them, and drives the vending machine's 2-bit coin code with single-cycle events. When the machine is not accepting coins, a qualified coin is reported on a reject strobe and is not forwarded.

## Interface
- DEBOUNCE_CYC, default 1000: consecutive synchronized cycles a level must persist to count as stable. Legal range is ≥2; counter width is $clog2(DEBOUNCE_CYC).
- clk  input  1  system clock.
- rst  input  1  synchronous reset, active-high.
- sw_half  input  1  raw 0.5-yuan slot sensor, active-high, asynchronous, bouncy.
- sw_one  input  1  raw 1-yuan slot sensor, active-high, asynchronous, bouncy.
- accept_en  input  1  1 = coins are forwarded; 0 = coins are rejected.
- coin  output  2  single-cycle coin code to the vending machine: 2'b00 none, 2'b01 0.5 yuan, 2'b10 1 yuan. 2'b11 is never driven.
- reject  output  2  single-cycle reject code, same encoding as coin.

## Operation
- **Synchronizer:** each sensor passes through a 2-flop synchronizer. The synchronized level is called s_half / s_one.
- **Per-channel FSM:** one per channel, each with its own debounce counter cnt.
  - IDLE:
    - s=0: cnt←0.
    - s=1: cnt←cnt+1.
    - s=1 and cnt==DEBOUNCE_CYC-1: raise the channel's qualify strobe for one cycle, cnt←0, go to HELD.
  - HELD:
    - s=1: cnt←0.
    - s=0: cnt←cnt+1.
    - s=0 and cnt==DEBOUNCE_CYC-1: cnt←0, go to IDLE. No output on release.
- **Reset state is HELD for both channels.** A sensor stuck high through reset produces no phantom coin; it must read stably low before any coin can be qualified.
- **Arbiter:** combines the qualify strobes into one event per cycle.
  - 1-yuan has priority.
  - If both qualify in the same cycle, the 1-yuan event is issued in that cycle and the half event is latched in half_pend, then issued the next cycle.
  - One pending slot is sufficient: a channel cannot requalify within DEBOUNCE_CYC (≥2) cycles.
- **Output steering:** accept_en is sampled in the cycle an event is issued (including a deferred half event).
  - accept_en=1: coin←code, reject←00.
  - accept_en=0: reject←code, coin←00.
- coin and reject are registered and are never both nonzero.
- **Reset mid-operation:** all counters, the pending flag, coin and reject clear. Both FSMs return to HELD and any coin in progress is discarded.

## Timing
- Reset values: coin=2'b00, reject=2'b00, half_pend=0, cnt=0, FSMs=HELD.
- Latency: with a raw sensor steadily high starting at cycle 0 (FSM in IDLE), the event appears on coin/reject for exactly one cycle at cycle DEBOUNCE_CYC+2, i.e. 2 synchronizer cycles plus DEBOUNCE_CYC counting cycles with the output register folded in. A deferred half event appears one cycle later.
- Glitch rejection:
  - A high pulse shorter than DEBOUNCE_CYC synchronized cycles in IDLE produces nothing.
  - A low glitch shorter than DEBOUNCE_CYC in HELD produces no second coin.
- Exactly one coin or reject event is produced per qualified press, regardless of press length.
- No handshake: the consumer samples coin every clk edge.

## Test plan
All scenarios use DEBOUNCE_CYC=4 unless noted.
1. **Reset with stuck sensor:** rst=1 for 3 cycles with sw_one=1, hold sw_one high 20 more cycles -> coin=00 and reject=00 throughout. Then drop sw_one for ≥6 cycles and raise it -> coin=10 for one cycle, 6 cycles after the rise.
2. **Clean press:** after idle release, sw_half high for 10 cycles, accept_en=1 -> coin=01 for one cycle at rise+6; no other nonzero coin.
3. **Bouncy press:** sw_one toggles every 2 cycles for 12 cycles, then stays high for 10 -> exactly one coin=10, at steady-rise+6. A bouncy release of the same shape produces no further event.
4. **Simultaneous:** sw_half and sw_one rise in the same cycle -> coin=10 at rise+6, coin=01 at rise+7, coin=00 otherwise.
5. **Reject:** accept_en=0, sw_one press -> reject=10 for one cycle at rise+6, coin stays 00. Repeat the simultaneous case with accept_en dropping after the first event -> coin=10 then reject=01.
6. **Reset mid-debounce:** assert rst at rise+4 of a half press -> no event. After rst release, the sensor still high yields no coin until it releases and re-presses.
